pc_sequencer: RTL
=================

# pc_sequencer

Fetch-stage controller that sequences the program counter register: each cycle it decides whether the PC advances and to which address. It arbitrates sequential increment, branch/jump, trap and mret redirects, and debug halt/resume. It also owns the instruction-memory request handshake. It sits in IF1 between the EX/CSR redirect sources and the PC register, driving the PC register's enable and next-PC inputs.

## Interface
- No parameters.
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- current_pc_if1  in  32  current PC from the PC register
- next_pc_if1  out  32  next PC to the PC register (combinational)
- pc_en  out  1  PC register load enable (combinational)
- imem_req  out  1  fetch request at address current_pc_if1
- imem_ready  in  1  imem accepts the request this cycle
- stall_if1  in  1  IF backpressure; blocks new requests
- flush_if  out  1  discard the in-flight fetch; asserted with every redirect load
- branch_taken_ex  in  1  branch/jump redirect request
- branch_target_ex  in  32  branch target
- trap_req  in  1  trap redirect request
- trap_target  in  32  trap vector
- mret_req  in  1  mret redirect request
- mret_target  in  32  mepc value
- dbg_halt_req  in  1  debug halt request (level)
- dbg_resume_req  in  1  debug resume pulse
- dbg_resume_pc  in  32  resume address (dpc)
- dbg_halted  out  1  core fetch halted
- redirect_pending  out  1  a captured redirect awaits application

## Operation
- FSM states: BOOT, RUN, HALT_WAIT, HALTED.
- Reset values:
  - State is BOOT; pending_valid and req_hold_q are 0.
  - pc_en, imem_req, flush_if, dbg_halted and redirect_pending are all 0.
  - next_pc_if1 is current_pc_if1+4.
- BOOT→RUN unconditionally after one cycle. This lets the PC reset value settle; no fetch is issued in BOOT.
- req_hold_q:
  - Set when imem_req && !imem_ready.
  - Cleared when imem_ready.
  - While set, imem_req stays high and current_pc_if1 must not change.
- imem_req = (RUN && (req_hold_q || !stall_if1)) || (HALT_WAIT && req_hold_q).
- Redirect priority: trap > mret > branch. A new request of equal or higher class than the pending one wins; a lower-class request is dropped.
- In RUN, the first matching row applies:
  - Redirect available (new or pending) and (!imem_req || imem_ready): pc_en=1, next_pc=selected target, flush_if=1, pending cleared.
  - Else imem_req && imem_ready: pc_en=1, next_pc=current_pc_if1+4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000).
  - Else pc_en=0. Any new redirect is latched into pending (target + class); redirect_pending=1.
- Halt:
  - dbg_halt_req in RUN moves to HALT_WAIT if req_hold_q or (imem_req && !imem_ready); otherwise it goes directly to HALTED.
  - A redirect or advance in that same cycle still completes.
  - HALT_WAIT→HALTED on imem_ready.
- HALTED:
  - imem_req=0 and dbg_halted=1.
  - Redirects are still captured into pending.
- Resume: dbg_resume_req in HALTED gives pc_en=1, next_pc=dbg_resume_pc, pending cleared, flush_if=1, then →RUN.
- dbg_resume_req outside HALTED is ignored.
- Reset asserted mid-operation returns everything to reset values immediately. A pending redirect is lost.

## Timing
- pc_en, next_pc_if1, flush_if and imem_req are combinational from inputs and state. The PC register updates at the following clk edge.
- A redirect that is accepted immediately is visible on current_pc_if1 one cycle later. A captured redirect is applied in the first cycle its row condition holds.
- Halt latency: 1 cycle if no request is outstanding, otherwise 1 cycle after imem_ready.
- Resume: fetch from dbg_resume_pc starts 1 cycle after dbg_resume_req.

## Configuration
- PC_DBG_HALT_EN defined: HALT_WAIT/HALTED states and the behaviour above.
- PC_DBG_HALT_EN undefined:
  - dbg_halt_req and dbg_resume_req are ignored and dbg_halted is tied to 0.
  - The FSM is BOOT/RUN only.
  - Ports remain present.

## Test plan
- Reset release, imem_ready=1, no stall, PC=0xFFFFF000: BOOT 1 cycle, then pc_en each cycle; the PC sequence is 0xFFFFF000, 0xFFFFF004, …
- Branch to 0x80000100 while imem_ready=0 with a request held: pc_en=0 and redirect_pending=1. In the cycle imem_ready=1, next_pc=0x80000100 and flush_if=1.
- Same-cycle trap (0x80000004) and branch (0x80000200) while blocked: pending holds the trap. A later branch does not overwrite it, and the PC loads 0x80000004.
- PC=0xFFFFFFFC, sequential advance: next_pc=0x00000000.
- dbg_halt_req with an outstanding request: HALT_WAIT until imem_ready, then dbg_halted=1 and imem_req=0. dbg_resume_req with dbg_resume_pc=0x80000040 loads the PC and returns to RUN.
- Reset asserted with a pending redirect: all outputs return to 0 and pending is cleared. After release, BOOT repeats.

Source files
------------

// File: rtl/pc_sequencer.sv
// IF1 program-counter sequencer: arbitrates increment, branch/trap/mret redirects and debug halt/resume.
// Optional macro PC_DBG_HALT_EN adds the HALT_WAIT/HALTED states; without it the FSM is BOOT/RUN only.
module pc_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] current_pc_if1,
   output logic [31:0] next_pc_if1,
   output logic        pc_en,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic        stall_if1,
   output logic        flush_if,
   input  logic        branch_taken_ex,
   input  logic [31:0] branch_target_ex,
   input  logic        trap_req,
   input  logic [31:0] trap_target,
   input  logic        mret_req,
   input  logic [31:0] mret_target,
   input  logic        dbg_halt_req,
   input  logic        dbg_resume_req,
   input  logic [31:0] dbg_resume_pc,
   output logic        dbg_halted,
   output logic        redirect_pending
);

`ifdef PC_DBG_HALT_EN
   typedef enum logic [1:0] {BOOT, RUN, HALT_WAIT, HALTED} state_e;
`else
   typedef enum logic {BOOT, RUN} state_e;
`endif

   localparam logic [1:0] CLS_NONE   = 2'd0;
   localparam logic [1:0] CLS_BRANCH = 2'd1;
   localparam logic [1:0] CLS_MRET   = 2'd2;
   localparam logic [1:0] CLS_TRAP   = 2'd3;

   state_e      state_q, state_d;
   logic        hold_q, hold_d;
   logic        pend_valid_q, pend_valid_d;
   logic [1:0]  pend_cls_q, pend_cls_d;
   logic [31:0] pend_tgt_q, pend_tgt_d;

   logic [1:0]  new_cls;
   logic [31:0] new_tgt;
   logic [1:0]  pend_cls_eff;
   logic        new_wins;
   logic        redir_avail;
   logic [31:0] sel_tgt;
   logic [31:0] pc_plus4;

`ifndef PC_DBG_HALT_EN
   logic unused_dbg;
   assign unused_dbg = ^{dbg_halt_req, dbg_resume_req, dbg_resume_pc};
`endif

   always_comb begin
      new_cls = CLS_NONE;
      new_tgt = branch_target_ex;
      if (trap_req) begin
         new_cls = CLS_TRAP;
         new_tgt = trap_target;
      end else if (mret_req) begin
         new_cls = CLS_MRET;
         new_tgt = mret_target;
      end else if (branch_taken_ex) begin
         new_cls = CLS_BRANCH;
         new_tgt = branch_target_ex;
      end
   end

   // An equal-class newcomer replaces the pending target; a lower class is dropped.
   assign pend_cls_eff     = pend_valid_q ? pend_cls_q : CLS_NONE;
   assign new_wins         = (new_cls != CLS_NONE) && (new_cls >= pend_cls_eff);
   assign redir_avail      = new_wins || pend_valid_q;
   assign sel_tgt          = new_wins ? new_tgt : pend_tgt_q;
   assign pc_plus4         = current_pc_if1 + 32'd4;
   assign redirect_pending = pend_valid_q;

   // Handshake: a request raised with imem_ready low is held, at a frozen PC, until imem_ready.
`ifdef PC_DBG_HALT_EN
   assign imem_req = ((state_q == RUN) && (hold_q || !stall_if1)) ||
                     ((state_q == HALT_WAIT) && hold_q);
`else
   assign imem_req = (state_q == RUN) && (hold_q || !stall_if1);
`endif

   always_comb begin
      hold_d = hold_q;
      if (imem_ready) begin
         hold_d = 1'b0;
      end else if (imem_req) begin
         hold_d = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      pend_valid_d = pend_valid_q;
      pend_cls_d   = pend_cls_q;
      pend_tgt_d   = pend_tgt_q;
      pc_en        = 1'b0;
      next_pc_if1  = pc_plus4;
      flush_if     = 1'b0;
      dbg_halted   = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (redir_avail && (!imem_req || imem_ready)) begin
               pc_en        = 1'b1;
               next_pc_if1  = sel_tgt;
               flush_if     = 1'b1;
               pend_valid_d = 1'b0;
            end else if (imem_req && imem_ready) begin
               pc_en = 1'b1;
            end else if (new_wins) begin
               pend_valid_d = 1'b1;
               pend_cls_d   = new_cls;
               pend_tgt_d   = new_tgt;
            end
`ifdef PC_DBG_HALT_EN
            if (dbg_halt_req) begin
               state_d = (hold_q || (imem_req && !imem_ready)) ? HALT_WAIT : HALTED;
            end
`endif
         end
`ifdef PC_DBG_HALT_EN
         HALT_WAIT: begin
            if (new_wins) begin
               pend_valid_d = 1'b1;
               pend_cls_d   = new_cls;
               pend_tgt_d   = new_tgt;
            end
            if (imem_ready) begin
               state_d = HALTED;
            end
         end
         HALTED: begin
            dbg_halted = 1'b1;
            if (dbg_resume_req) begin
               pc_en        = 1'b1;
               next_pc_if1  = dbg_resume_pc;
               flush_if     = 1'b1;
               pend_valid_d = 1'b0;
               state_d      = RUN;
            end else if (new_wins) begin
               pend_valid_d = 1'b1;
               pend_cls_d   = new_cls;
               pend_tgt_d   = new_tgt;
            end
         end
`endif
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= BOOT;
         hold_q       <= 1'b0;
         pend_valid_q <= 1'b0;
         pend_cls_q   <= CLS_NONE;
         pend_tgt_q   <= 32'd0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         pend_valid_q <= pend_valid_d;
         pend_cls_q   <= pend_cls_d;
         pend_tgt_q   <= pend_tgt_d;
      end
   end

endmodule
